// File: rtl/noc_packet_injector.sv
// Source-side network interface. It turns one destination request plus a payload word
// stream into a HEAD/BODY.../TAIL packet for the router's local input port.
module noc_packet_injector #(
  parameter int N             = 4,
  parameter int INDEX         = 0,
  parameter int DATA_WIDTH    = 32,
  parameter int TYPE_WIDTH    = 2,
  parameter int FlitPerPacket = 6,
  parameter int CNT_WIDTH     = 16,
  parameter int DEST_W        = (N > 1) ? $clog2(N) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [DEST_W-1:0]            req_dest_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [DATA_WIDTH-TYPE_WIDTH-1:0] pl_data_i,
  input  logic                         pl_valid_i,
  output logic                         pl_ready_o,
  output logic [DATA_WIDTH-1:0]        flit_data_o,
  output logic                         flit_valid_o,
  input  logic                         flit_ready_i,
  output logic                         busy_o,
  output logic                         err_dest_o,
  output logic [CNT_WIDTH-1:0]         pkt_count_o
);

  localparam int CW = (FlitPerPacket > 2) ? $clog2(FlitPerPacket) : 1;

  localparam logic [TYPE_WIDTH-1:0] T_HEAD = TYPE_WIDTH'(1);
  localparam logic [TYPE_WIDTH-1:0] T_BODY = TYPE_WIDTH'(2);
  localparam logic [TYPE_WIDTH-1:0] T_TAIL = TYPE_WIDTH'(3);

  localparam logic [CW-1:0]     LAST_CNT = CW'(FlitPerPacket - 2);
  localparam logic [DEST_W:0]   N_LIM    = (DEST_W + 1)'(N);
  localparam logic [DEST_W-1:0] SRC_ID   = DEST_W'(INDEX);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_PAYLOAD = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] flit_data_q, flit_data_d;
  logic                  flit_valid_q, flit_valid_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  pkt_count_q;

  logic                  slot_free;
  logic                  req_fire;
  logic                  pl_fire;
  logic                  dest_ok;
  logic                  tail_fire;
  logic [DATA_WIDTH-1:0] head_flit;

  // The output register can take a new flit when empty or draining this cycle.
  assign slot_free = ~flit_valid_q | flit_ready_i;

  assign req_ready_o = ~rst_i & (state_q == S_IDLE) & slot_free;
  assign pl_ready_o  = ~rst_i & (state_q == S_PAYLOAD) & slot_free;
  assign busy_o      = ~rst_i & ((state_q == S_PAYLOAD) | flit_valid_q);

  assign req_fire  = req_valid_i & req_ready_o;
  assign pl_fire   = pl_valid_i & pl_ready_o;
  assign dest_ok   = {1'b0, req_dest_i} < N_LIM;
  assign tail_fire = flit_valid_q & flit_ready_i &
                     (flit_data_q[DATA_WIDTH-1 -: TYPE_WIDTH] == T_TAIL);

  always_comb begin
    head_flit = '0;
    head_flit[DATA_WIDTH-1 -: TYPE_WIDTH] = T_HEAD;
    head_flit[2*DEST_W-1 -: DEST_W]       = SRC_ID;
    head_flit[DEST_W-1:0]                 = req_dest_i;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flit_data_d  = flit_data_q;
    flit_valid_d = flit_valid_q & ~flit_ready_i;
    err_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          if (dest_ok) begin
            flit_data_d  = head_flit;
            flit_valid_d = 1'b1;
            cnt_d        = '0;
            state_d      = S_PAYLOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (pl_fire) begin
          flit_valid_d = 1'b1;
          if (cnt_q == LAST_CNT) begin
            flit_data_d = {T_TAIL, pl_data_i};
            cnt_d       = '0;
            state_d     = S_IDLE;
          end else begin
            flit_data_d = {T_BODY, pl_data_i};
            cnt_d       = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      flit_data_q  <= '0;
      flit_valid_q <= 1'b0;
      err_q        <= 1'b0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flit_data_q  <= flit_data_d;
      flit_valid_q <= flit_valid_d;
      err_q        <= err_d;
      if (tail_fire) pkt_count_q <= pkt_count_q + CNT_WIDTH'(1);
    end
  end

  assign flit_data_o  = flit_data_q;
  assign flit_valid_o = flit_valid_q;
  assign err_dest_o   = err_q;
  assign pkt_count_o  = pkt_count_q;

endmodule

// File: tb/tb_noc_packet_injector.sv
// Self-checking bench for noc_packet_injector: randomized packets compared against a
// queue-based packet model; a second instance with a wider dest field covers bad dests.
module tb_noc_packet_injector;

  localparam int IDX = 1;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  req_dest;
  logic        req_valid, req_ready_o;
  logic [29:0] pl_data;
  logic        pl_valid, pl_ready_o;
  logic [31:0] flit_data_o;
  logic        flit_valid_o, flit_ready;
  logic        busy_o, err_dest_o;
  logic [15:0] pkt_count_o;

  logic [2:0]  e_req_dest;
  logic        e_req_valid, e_req_ready;
  logic [29:0] e_pl_data;
  logic        e_pl_valid, e_pl_ready;
  logic [31:0] e_flit_data;
  logic        e_flit_valid, e_flit_ready;
  logic        e_busy, e_err;
  logic [15:0] e_pkt_count;

  always #5 clk_i = ~clk_i;

  noc_packet_injector #(.N(4), .INDEX(IDX)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_dest_i(req_dest), .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .pl_data_i(pl_data), .pl_valid_i(pl_valid), .pl_ready_o(pl_ready_o),
    .flit_data_o(flit_data_o), .flit_valid_o(flit_valid_o), .flit_ready_i(flit_ready),
    .busy_o(busy_o), .err_dest_o(err_dest_o), .pkt_count_o(pkt_count_o)
  );

  noc_packet_injector #(.N(4), .INDEX(IDX), .DEST_W(3)) dut_e (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_dest_i(e_req_dest), .req_valid_i(e_req_valid), .req_ready_o(e_req_ready),
    .pl_data_i(e_pl_data), .pl_valid_i(e_pl_valid), .pl_ready_o(e_pl_ready),
    .flit_data_o(e_flit_data), .flit_valid_o(e_flit_valid), .flit_ready_i(e_flit_ready),
    .busy_o(e_busy), .err_dest_o(e_err), .pkt_count_o(e_pkt_count)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [31:0] obs_q[$];
  int          obs_cyc[$];
  logic [31:0] exp_q[$];
  int          req_q[$];
  logic [29:0] pl_q[$];
  int          exp_pkts = 0;
  logic [31:0] stall_word;
  int          stall_cycles, stall_bad;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Router side: every flit accepted at the coming edge is logged.
  always @(negedge clk_i) begin
    if (!rst_i && flit_valid_o && flit_ready) begin
      obs_q.push_back(flit_data_o);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic clear_model();
    obs_q.delete(); obs_cyc.delete(); exp_q.delete(); req_q.delete(); pl_q.delete();
  endtask

  // Packet model: HEAD carries type 01, src at [3:2], dest at [1:0]; then 4 BODY, 1 TAIL.
  task automatic add_pkt(input int dest, input logic [29:0] first, input bit rnd);
    logic [29:0] w;
    req_q.push_back(dest);
    exp_q.push_back(32'h4000_0000 + 32'(IDX * 4) + 32'(dest));
    for (int i = 0; i < 5; i++) begin
      w = rnd ? 30'($urandom) : first + 30'(i);
      pl_q.push_back(w);
      exp_q.push_back(((i == 4) ? 32'hC000_0000 : 32'h8000_0000) | {2'b00, w});
    end
    exp_pkts++;
  endtask

  // mode 0: always ready/valid, 1: random gaps and backpressure, 2: one 3-cycle stall on stall_word
  task automatic send(input int mode, input int abort_at, output bit to, output int rc);
    bit done = 0;
    bit stall_used = 0;
    int stall_left = 0;
    to = 0;
    rc = -1;
    stall_cycles = 0;
    stall_bad = 0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(posedge clk_i);
      #1;
      if (abort_at > 0 && obs_q.size() >= abort_at) begin
        req_valid = 0; pl_valid = 0; rst_i = 1; done = 1;
      end else if (req_q.size() == 0 && pl_q.size() == 0 && !flit_valid_o) begin
        done = 1;
      end else begin
        req_valid = (req_q.size() > 0) && (mode != 1 || $urandom_range(3) != 0);
        req_dest  = req_valid ? 2'(req_q[0]) : 2'($urandom);
        pl_valid  = (pl_q.size() > 0) && (mode != 1 || $urandom_range(3) != 0);
        pl_data   = pl_valid ? pl_q[0] : 30'($urandom);
        case (mode)
          1: flit_ready = ($urandom_range(9) < 6);
          2: begin
            if (stall_left > 0) begin
              flit_ready = 0; stall_left--;
            end else if (!stall_used && flit_valid_o && flit_data_o == stall_word) begin
              flit_ready = 0; stall_used = 1; stall_left = 2;
            end else flit_ready = 1;
          end
          default: flit_ready = 1;
        endcase
        #1;
        if (mode == 2 && !flit_ready) begin
          stall_cycles++;
          if (flit_data_o !== stall_word || pl_ready_o !== 1'b0 || flit_valid_o !== 1'b1)
            stall_bad++;
        end
        if (req_valid && req_ready_o) begin void'(req_q.pop_front()); rc = cyc; end
        if (pl_valid && pl_ready_o) void'(pl_q.pop_front());
      end
    end
    if (!done) to = 1;
    req_valid = 0;
    pl_valid = 0;
    flit_ready = 1;
  endtask

  task automatic test_reset();
    rst_i = 1; req_valid = 1; req_dest = 2'd1; pl_valid = 1; flit_ready = 1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    total++; if (req_ready_o !== 1'b0) $display("FAIL rst_req_ready: got %b want 0", req_ready_o); else passed++;
    total++; if (pl_ready_o !== 1'b0) $display("FAIL rst_pl_ready: got %b want 0", pl_ready_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_o); else passed++;
    total++; if (flit_valid_o !== 1'b0) $display("FAIL rst_flit_valid: got %b want 0", flit_valid_o); else passed++;
    total++; if (flit_data_o !== 32'h0) $display("FAIL rst_flit_data: got %h want 0", flit_data_o); else passed++;
    total++; if (err_dest_o !== 1'b0) $display("FAIL rst_err: got %b want 0", err_dest_o); else passed++;
    total++; if (pkt_count_o !== 16'h0) $display("FAIL rst_pkt_count: got %h want 0", pkt_count_o); else passed++;
    req_valid = 0; rst_i = 0;
    @(negedge clk_i);
    total++; if (req_ready_o !== 1'b1) $display("FAIL idle_req_ready: got %b want 1", req_ready_o); else passed++;
    @(negedge clk_i);
    total++; if (pl_ready_o !== 1'b0) $display("FAIL idle_pl_ignored: got %b want 0", pl_ready_o); else passed++;
    total++; if (busy_o !== 1'b0 || flit_valid_o !== 1'b0)
      $display("FAIL idle_quiet: busy %b valid %b want 0 0", busy_o, flit_valid_o); else passed++;
    pl_valid = 0;
  endtask

  task automatic test_single();
    logic [31:0] lit[6];
    bit to; int rc;
    lit = '{32'h4000_0006, 32'h8000_0011, 32'h8000_0012, 32'h8000_0013, 32'h8000_0014, 32'hC000_0015};
    clear_model();
    add_pkt(2, 30'h11, 0);
    send(0, 0, to, rc);
    total++; if (to) $display("FAIL single_timeout: got timeout want done"); else passed++;
    total++; if (obs_q.size() != 6) $display("FAIL single_count: got %0d want 6", obs_q.size()); else passed++;
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== lit[i]) $display("FAIL single_flit%0d: got %h want %h", i, obs_q[i], lit[i]); else passed++;
      total++; if (obs_cyc[i] != obs_cyc[0] + i)
        $display("FAIL single_gap%0d: got cycle %0d want %0d", i, obs_cyc[i], obs_cyc[0] + i); else passed++;
    end
    if (obs_q.size() > 0) begin
      total++; if (obs_cyc[0] != rc + 1) $display("FAIL head_latency: got %0d want %0d", obs_cyc[0], rc + 1); else passed++;
    end
    total++; if (pkt_count_o !== 16'(exp_pkts)) $display("FAIL single_pkt_count: got %0d want %0d", pkt_count_o, exp_pkts); else passed++;
  endtask

  task automatic test_stall();
    bit to; int rc;
    clear_model();
    stall_word = 32'h8000_0012;
    add_pkt(2, 30'h11, 0);
    send(2, 0, to, rc);
    total++; if (to) $display("FAIL stall_timeout: got timeout want done"); else passed++;
    total++; if (stall_cycles != 3) $display("FAIL stall_len: got %0d want 3", stall_cycles); else passed++;
    total++; if (stall_bad != 0) $display("FAIL stall_hold: got %0d bad cycles want 0", stall_bad); else passed++;
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL stall_count: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) $display("FAIL stall_flit%0d: got %h want %h", i, obs_q[i], exp_q[i]); else passed++;
    end
    total++; if (pkt_count_o !== 16'(exp_pkts)) $display("FAIL stall_pkt_count: got %0d want %0d", pkt_count_o, exp_pkts); else passed++;
  endtask

  task automatic test_back_to_back();
    bit to; int rc;
    clear_model();
    add_pkt(3, 30'h0, 1);
    add_pkt(0, 30'h0, 1);
    send(0, 0, to, rc);
    total++; if (to) $display("FAIL b2b_timeout: got timeout want done"); else passed++;
    total++; if (obs_q.size() != 12) $display("FAIL b2b_count: got %0d want 12", obs_q.size()); else passed++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_flit%0d: got %h want %h", i, obs_q[i], exp_q[i]); else passed++;
    end
    if (obs_q.size() >= 7) begin
      total++; if (obs_cyc[6] - obs_cyc[5] > 2)
        $display("FAIL b2b_gap: got %0d cycles want <=2", obs_cyc[6] - obs_cyc[5]); else passed++;
    end
    total++; if (pkt_count_o !== 16'(exp_pkts)) $display("FAIL b2b_pkt_count: got %0d want %0d", pkt_count_o, exp_pkts); else passed++;
  endtask

  task automatic test_err_dest();
    int dests[2];
    int seen_valid = 0;
    dests = '{4, 5};
    for (int k = 0; k < 2; k++) begin
      @(posedge clk_i); #1;
      e_req_valid = 1; e_req_dest = 3'(dests[k]);
      #1;
      total++; if (e_req_ready !== 1'b1) $display("FAIL err_req_ready%0d: got %b want 1", k, e_req_ready); else passed++;
      @(posedge clk_i); #1;
      e_req_valid = 0;
      @(negedge clk_i);
      if (e_flit_valid) seen_valid++;
      total++; if (e_err !== 1'b1) $display("FAIL err_pulse%0d: got %b want 1", k, e_err); else passed++;
      total++; if (e_busy !== 1'b0) $display("FAIL err_busy%0d: got %b want 0", k, e_busy); else passed++;
      @(negedge clk_i);
      if (e_flit_valid) seen_valid++;
      total++; if (e_err !== 1'b0) $display("FAIL err_width%0d: got %b want 0", k, e_err); else passed++;
    end
    total++; if (seen_valid != 0) $display("FAIL err_no_flit: got %0d valid cycles want 0", seen_valid); else passed++;
    total++; if (e_req_ready !== 1'b1) $display("FAIL err_stays_idle: got %b want 1", e_req_ready); else passed++;
    total++; if (e_pkt_count !== 16'h0) $display("FAIL err_pkt_count: got %0d want 0", e_pkt_count); else passed++;
  endtask

  task automatic test_random();
    bit to; int rc;
    clear_model();
    for (int p = 0; p < 6; p++) add_pkt($urandom_range(3), 30'h0, 1);
    send(1, 0, to, rc);
    total++; if (to) $display("FAIL rand_timeout: got timeout want done"); else passed++;
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) $display("FAIL rand_flit%0d: got %h want %h", i, obs_q[i], exp_q[i]); else passed++;
    end
    total++; if (pkt_count_o !== 16'(exp_pkts)) $display("FAIL rand_pkt_count: got %0d want %0d", pkt_count_o, exp_pkts); else passed++;
  endtask

  task automatic test_reset_mid();
    bit to; int rc; int tails = 0;
    clear_model();
    add_pkt(1, 30'h0, 1);
    send(0, 3, to, rc);
    @(posedge clk_i); #1;
    rst_i = 0;
    @(negedge clk_i);
    total++; if (flit_valid_o !== 1'b0) $display("FAIL midrst_valid: got %b want 0", flit_valid_o); else passed++;
    total++; if (pkt_count_o !== 16'h0) $display("FAIL midrst_pkt_count: got %0d want 0", pkt_count_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy_o); else passed++;
    repeat (3) @(negedge clk_i);
    foreach (obs_q[i]) if (obs_q[i][31:30] == 2'b11) tails++;
    total++; if (tails != 0) $display("FAIL midrst_no_tail: got %0d tails want 0", tails); else passed++;
    clear_model();
    exp_pkts = 0;
    add_pkt(0, 30'h0, 1);
    send(0, 0, to, rc);
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL midrst_count: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) $display("FAIL midrst_flit%0d: got %h want %h", i, obs_q[i], exp_q[i]); else passed++;
    end
    total++; if (pkt_count_o !== 16'(exp_pkts)) $display("FAIL midrst_new_count: got %0d want %0d", pkt_count_o, exp_pkts); else passed++;
  endtask

  task automatic test_wrap();
    bit to; int rc;
    @(negedge clk_i);
    force dut.pkt_count_q = 16'hFFFF;
    #1 release dut.pkt_count_q;
    #1;
    total++; if (pkt_count_o !== 16'hFFFF) $display("FAIL wrap_preload: got %h want ffff", pkt_count_o); else passed++;
    clear_model();
    add_pkt(2, 30'h0, 1);
    send(0, 0, to, rc);
    total++; if (obs_q.size() != 6) $display("FAIL wrap_count: got %0d want 6", obs_q.size()); else passed++;
    total++; if (pkt_count_o !== 16'h0000) $display("FAIL wrap_pkt_count: got %h want 0000", pkt_count_o); else passed++;
  endtask

  initial begin
    rst_i = 1; req_valid = 0; req_dest = 0; pl_valid = 0; pl_data = 0; flit_ready = 1;
    e_req_valid = 0; e_req_dest = 0; e_pl_valid = 0; e_pl_data = 0; e_flit_ready = 1;
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_err_dest();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d/%0d passed so far", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
